ram_host_ctrl: RTL and testbench
================================

# ram_host_ctrl

Host-side command sequencer that drives the RAM command/data bus from the initiator end. The RAM controller side receives cs/ras/cas/act/rwb, bank, row, column, burst and write data, and returns read data. This block turns simple request transactions into legal PRE/ACT/READ/WRITE sequences. It tracks the open row per bank, enforces activate/precharge/CAS-latency delays, streams write beats out and captures read beats back.

## Interface
- T_RCD, 2: cycles from ACT to READ/WRITE (≥1).
- T_RP, 2: cycles from PRE (or end of auto-precharge burst) to next ACT (≥1).
- T_CL, 2: cycles from READ command to first valid dataout beat (≥1).
- clk_t  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept; high only in IDLE.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  9  {bank_grp, bank_no[1:0], row[2:0], col[2:0]}.
- req_len  input  3  burst length − 1 (1..8 beats).
- req_ap  input  1  auto-precharge after burst.
- wdata  input  16  write beat, sampled in cycles with wd_ready=1.
- wd_ready  output  1  write-beat pull strobe.
- rd_data  output  16  registered read beat.
- rd_valid  output  1  rd_data valid.
- cs, act, ras, cas, rwb, auto_pre, burst_mode  output  1 each  command pins.
- bank_grp  output  1; bank_no  output  2; row_address  output  3; col_address  output  3; burst_len  output  3.
- datain  output  16  write data to RAM; dataout  input  16  read data from RAM.

## Operation
- Command encoding, one cycle each:
  - NOP: cs=1, act=0, ras=1, cas=1, rwb=1.
  - ACT: cs=0, act=1, ras=0, cas=1.
  - READ: cs=0, act=0, ras=1, cas=0, rwb=1.
  - WRITE: same as READ with rwb=0.
  - PRE: cs=0, act=0, ras=0, cas=1, rwb=0.
- ACT drives bank and row. PRE drives bank. READ/WRITE drive bank, col_address, burst_len=req_len, burst_mode=(req_len≠0) and auto_pre=req_ap.
- Open-row table: 8 entries (indexed {bank_grp,bank_no}) of valid + 3-bit row.
- Request accepted on req_valid & req_ready; all fields registered.
- Decision on accept:
  - hit (valid & row match): go to RW.
  - closed: go to ACT.
  - miss: go to PRE.
- FSM: IDLE → PRE → PRE_WAIT (T_RP−1) → ACT → ACT_WAIT (T_RCD−1) → RW → WBURST/RBURST → (AP_WAIT if req_ap) → IDLE.
  - ACT sets table entry valid with the new row.
  - PRE clears the entry.
  - Auto-precharge clears the entry on entering AP_WAIT. AP_WAIT lasts T_RP cycles.
- Write: wd_ready=1 in cycles C..C+len (C = WRITE cycle). Beat k sampled at C+k, driven on datain at C+1+k.
- Read: dataout sampled at C+T_CL+k. rd_data/rd_valid high at C+T_CL+1+k, k=0..len.
- Beat counter is 3-bit and counts 0..req_len with no wrap beyond len.
- Address/bank outputs hold their last value during NOP. datain holds last beat.

## Timing
- Reset (asynchronous, immediate):
  - Outputs: cs=1, act=0, ras=1, cas=1, rwb=1, auto_pre=0, burst_mode=0; all address/burst fields 0; datain=0; rd_data=0; rd_valid=0; wd_ready=0; req_ready=0 while reset low.
  - State: FSM=IDLE; table all invalid. req_ready=1 first cycle after release.
- Reset mid-burst aborts the transaction. No further beats; open-row state is lost.
- Accept at cycle 0. First command at cycle 1:
  - Hit: RW at 1.
  - Closed: ACT at 1, RW at 1+T_RCD.
  - Miss: PRE at 1, ACT at 1+T_RP, RW at 1+T_RP+T_RCD.
- req_ready returns:
  - Write: at C+len+2.
  - Read: at C+T_CL+len+2.
  - Add T_RP cycles when req_ap=1.
- req_ready=0 from the accept edge until return to IDLE. req_valid while busy is held, not dropped.

## Test plan
- Write after reset to bank 0, row 5, col 2, len 3:
  - ACT at cycle 1 (row_address=5); WRITE at 3 (col_address=2, burst_len=3, burst_mode=1).
  - wd_ready at 3–6; datain = A0,A1,A2,A3 at 4–7; req_ready at 8.
- Read bank 0, row 5, col 2, len 3 (row hit), with dataout modelled at T_CL:
  - READ at cycle 1; dataout sampled at 3–6; rd_valid at 4–7 with matching data; req_ready at 8.
- Read bank 0, row 6 (row miss), len 0:
  - PRE at 1; ACT at 3 (row 6); READ at 5; rd_valid single beat at 8.
- Write with req_ap=1, len 0, row hit:
  - WRITE with auto_pre=1 at 1; AP_WAIT 2 cycles; req_ready at 5.
  - Next request to the same row issues ACT (entry cleared).
- Open bank_grp=1/bank 3, row 2, then bank 0 row 5: both entries stay valid. Revisit bank_grp=1/bank 3, row 2 → READ at cycle 1 (hit).
- Assert reset during RBURST beat 2:
  - All outputs go to reset values in the same cycle; rd_valid=0.
  - After release, a request to the previously open row issues ACT first.

Source files
------------

// File: rtl/ram_host_ctrl.sv
// Host-side RAM command sequencer: turns single requests into PRE/ACT/READ/WRITE
// sequences, tracks the open row per bank and streams write/read beats.
module ram_host_ctrl #(
  parameter int T_RCD  = 2,
  parameter int T_RP   = 2,
  parameter int T_CL   = 2,
  parameter int DATA_W = 16
) (
  input  logic              clk_t,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [8:0]        req_addr,
  input  logic [2:0]        req_len,
  input  logic              req_ap,
  input  logic [DATA_W-1:0] wdata,
  output logic              wd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              cs,
  output logic              act,
  output logic              ras,
  output logic              cas,
  output logic              rwb,
  output logic              auto_pre,
  output logic              burst_mode,
  output logic              bank_grp,
  output logic [1:0]        bank_no,
  output logic [2:0]        row_address,
  output logic [2:0]        col_address,
  output logic [2:0]        burst_len,
  output logic [DATA_W-1:0] datain,
  input  logic [DATA_W-1:0] dataout
);

  typedef enum logic [3:0] {
    IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, RW, WBURST, RBURST, AP_WAIT
  } state_t;

  // Pin order {cs, act, ras, cas, rwb}
  localparam logic [4:0] CMD_NOP = 5'b10111;
  localparam logic [4:0] CMD_ACT = 5'b01011;
  localparam logic [4:0] CMD_RD  = 5'b00101;
  localparam logic [4:0] CMD_WR  = 5'b00100;
  localparam logic [4:0] CMD_PRE = 5'b00010;

  localparam int WMAX   = (T_RP > T_RCD) ? ((T_RP > T_CL) ? T_RP : T_CL)
                                         : ((T_RCD > T_CL) ? T_RCD : T_CL);
  localparam int WAIT_W = $clog2(WMAX + 1);
  localparam logic [WAIT_W-1:0] RP_M1  = WAIT_W'(T_RP - 1);
  localparam logic [WAIT_W-1:0] RP_M2  = WAIT_W'(T_RP - 2);
  localparam logic [WAIT_W-1:0] RCD_M2 = WAIT_W'(T_RCD - 2);
  localparam logic [WAIT_W-1:0] CL_M1  = WAIT_W'(T_CL - 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [2:0]        beat;
  logic              tail;

  logic       we_q, ap_q;
  logic [2:0] idx_q, row_q, col_q, len_q;

  logic [7:0] row_vld;
  logic [2:0] row_tab [8];

  logic [2:0] req_idx, req_row, req_col;
  logic       req_hit, to_act, to_rw, burst_end;

  assign req_idx = req_addr[8:6];
  assign req_row = req_addr[5:3];
  assign req_col = req_addr[2:0];
  assign req_hit = row_vld[req_idx] && (row_tab[req_idx] == req_row);

  // Wait states of zero length are skipped by leaving PRE/ACT directly.
  assign to_act    = (state == PRE && T_RP == 1) || (state == PRE_WAIT && wait_cnt == '0);
  assign to_rw     = (state == ACT && T_RCD == 1) || (state == ACT_WAIT && wait_cnt == '0);
  assign burst_end = (state == WBURST && !wd_ready) || (state == RBURST && tail);

  always_ff @(posedge clk_t or negedge reset) begin
    if (!reset) begin
      state                    <= IDLE;
      wait_cnt                 <= '0;
      beat                     <= '0;
      tail                     <= 1'b0;
      req_ready                <= 1'b0;
      wd_ready                 <= 1'b0;
      rd_valid                 <= 1'b0;
      rd_data                  <= '0;
      datain                   <= '0;
      {cs, act, ras, cas, rwb} <= CMD_NOP;
      auto_pre                 <= 1'b0;
      burst_mode               <= 1'b0;
      bank_grp                 <= 1'b0;
      bank_no                  <= '0;
      row_address              <= '0;
      col_address              <= '0;
      burst_len                <= '0;
      we_q                     <= 1'b0;
      ap_q                     <= 1'b0;
      idx_q                    <= '0;
      row_q                    <= '0;
      col_q                    <= '0;
      len_q                    <= '0;
      row_vld                  <= '0;
      for (int i = 0; i < 8; i++) row_tab[i] <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!req_ready) begin
            req_ready <= 1'b1;
          end else if (req_valid) begin
            req_ready           <= 1'b0;
            we_q                <= req_we;
            ap_q                <= req_ap;
            idx_q               <= req_idx;
            row_q               <= req_row;
            col_q               <= req_col;
            len_q               <= req_len;
            {bank_grp, bank_no} <= req_idx;
            if (req_hit) begin
              state                    <= RW;
              {cs, act, ras, cas, rwb} <= req_we ? CMD_WR : CMD_RD;
              col_address              <= req_col;
              burst_len                <= req_len;
              burst_mode               <= |req_len;
              auto_pre                 <= req_ap;
              wd_ready                 <= req_we;
            end else if (row_vld[req_idx]) begin
              state                    <= PRE;
              {cs, act, ras, cas, rwb} <= CMD_PRE;
              row_vld[req_idx]         <= 1'b0;
            end else begin
              state                    <= ACT;
              {cs, act, ras, cas, rwb} <= CMD_ACT;
              row_address              <= req_row;
              row_vld[req_idx]         <= 1'b1;
              row_tab[req_idx]         <= req_row;
            end
          end
        end
        PRE: begin
          {cs, act, ras, cas, rwb} <= CMD_NOP;
          state                    <= PRE_WAIT;
          wait_cnt                 <= RP_M2;
        end
        PRE_WAIT: wait_cnt <= wait_cnt - 1'b1;
        ACT: begin
          {cs, act, ras, cas, rwb} <= CMD_NOP;
          state                    <= ACT_WAIT;
          wait_cnt                 <= RCD_M2;
        end
        ACT_WAIT: wait_cnt <= wait_cnt - 1'b1;
        RW: begin
          // Beat 0 is taken in the command cycle itself.
          {cs, act, ras, cas, rwb} <= CMD_NOP;
          if (we_q) begin
            datain   <= wdata;
            beat     <= 3'd1;
            wd_ready <= (len_q != 3'd0);
            state    <= WBURST;
          end else begin
            beat     <= 3'd0;
            tail     <= 1'b0;
            wait_cnt <= CL_M1;
            state    <= RBURST;
          end
        end
        WBURST: begin
          if (wd_ready) begin
            datain <= wdata;
            if (beat == len_q) wd_ready <= 1'b0;
            else               beat     <= beat + 3'd1;
          end
        end
        RBURST: begin
          if (!tail) begin
            if (wait_cnt != '0) begin
              wait_cnt <= wait_cnt - 1'b1;
            end else begin
              rd_data  <= dataout;
              rd_valid <= 1'b1;
              if (beat == len_q) tail <= 1'b1;
              else               beat <= beat + 3'd1;
            end
          end
        end
        AP_WAIT: begin
          if (wait_cnt == '0) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (to_act) begin
        state                    <= ACT;
        {cs, act, ras, cas, rwb} <= CMD_ACT;
        row_address              <= row_q;
        row_vld[idx_q]           <= 1'b1;
        row_tab[idx_q]           <= row_q;
      end
      if (to_rw) begin
        state                    <= RW;
        {cs, act, ras, cas, rwb} <= we_q ? CMD_WR : CMD_RD;
        col_address              <= col_q;
        burst_len                <= len_q;
        burst_mode               <= |len_q;
        auto_pre                 <= ap_q;
        wd_ready                 <= we_q;
      end
      if (burst_end) begin
        if (ap_q) begin
          state          <= AP_WAIT;
          wait_cnt       <= RP_M1;
          row_vld[idx_q] <= 1'b0;
        end else begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_host_ctrl.sv
// Scoreboard bench for ram_host_ctrl: a bank-table timing model predicts commands,
// write-beat pulls and read beats per absolute cycle; a monitor compares them.
module tb_ram_host_ctrl;
  localparam int T_RCD = 2;
  localparam int T_RP  = 2;
  localparam int T_CL  = 2;
  localparam int TAB   = 8192;

  logic        clk_t = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_ap = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [2:0]  req_len = '0;
  logic [15:0] wdata = '0, dataout = '0;
  logic        req_ready, wd_ready, rd_valid;
  logic [15:0] rd_data, datain;
  logic        cs, act, ras, cas, rwb, auto_pre, burst_mode, bank_grp;
  logic [1:0]  bank_no;
  logic [2:0]  row_address, col_address, burst_len;

  ram_host_ctrl #(.T_RCD(T_RCD), .T_RP(T_RP), .T_CL(T_CL), .DATA_W(16)) dut (
    .clk_t(clk_t), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_len(req_len), .req_ap(req_ap),
    .wdata(wdata), .wd_ready(wd_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .cs(cs), .act(act), .ras(ras), .cas(cas), .rwb(rwb), .auto_pre(auto_pre),
    .burst_mode(burst_mode), .bank_grp(bank_grp), .bank_no(bank_no),
    .row_address(row_address), .col_address(col_address), .burst_len(burst_len),
    .datain(datain), .dataout(dataout)
  );

  initial forever #5 clk_t = ~clk_t;

  int cyc = 0;
  always @(posedge clk_t) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  typedef struct { int cyc; int kind; logic [31:0] vec; } cmd_t;
  typedef struct { int cyc; logic [15:0] d; } beat_t;
  cmd_t  cmd_q[$];
  int    wr_q[$];
  beat_t din_q[$];
  beat_t rd_q[$];

  logic [15:0] wd_tab [TAB];
  logic [15:0] do_tab [TAB];
  bit          ovld [8];
  logic [2:0]  orow [8];

  localparam int K_PRE = 0, K_ACT = 1, K_RW = 2;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [8:0] mk(input int g, input int b, input int r, input int c);
    return {g[0], b[1:0], r[2:0], c[2:0]};
  endfunction

  // Input drivers: wdata/dataout in cycle n come from the tables at index n.
  initial forever begin
    @(negedge clk_t);
    wdata   = wd_tab[cyc % TAB];
    dataout = do_tab[cyc % TAB];
  end

  task automatic monitor_step();
    cmd_t  e;
    beat_t b;
    if (cs == 1'b0) begin
      if (cmd_q.size() == 0) begin
        check("cmd_unexpected_cs", 32'(cs), 32'd1);
      end else begin
        e = cmd_q.pop_front();
        check("cmd_cycle", cyc, e.cyc);
        case (e.kind)
          K_PRE:   check("pre_cmd", 32'({act, ras, cas, rwb, bank_grp, bank_no}), e.vec);
          K_ACT:   check("act_cmd", 32'({act, ras, cas, bank_grp, bank_no, row_address}), e.vec);
          default: check("rw_cmd", 32'({act, ras, cas, rwb, bank_grp, bank_no, col_address,
                                         burst_len, burst_mode, auto_pre}), e.vec);
        endcase
      end
    end else begin
      check("nop_pins", 32'({act, ras, cas, rwb}), 32'b0111);
    end
    if (wd_ready) begin
      if (wr_q.size() == 0) check("wd_ready_unexpected", 32'(wd_ready), 32'd0);
      else check("wd_ready_cycle", cyc, wr_q.pop_front());
    end
    if (din_q.size() != 0 && din_q[0].cyc == cyc) begin
      b = din_q.pop_front();
      check("datain", 32'(datain), 32'(b.d));
    end
    if (rd_valid) begin
      if (rd_q.size() == 0) begin
        check("rd_valid_unexpected", 32'(rd_valid), 32'd0);
      end else begin
        b = rd_q.pop_front();
        check("rd_cycle", cyc, b.cyc);
        check("rd_data", 32'(rd_data), 32'(b.d));
      end
    end
  endtask

  initial forever begin
    @(negedge clk_t);
    if (reset) monitor_step();
  end

  // Model: predict every bus event of one request from the open-row table and the
  // timing rules, then drive it. Called at a negedge.
  task automatic do_req(input bit we, input logic [8:0] addr, input logic [2:0] len,
                        input bit ap, input bit wait_done, output int c_out);
    int n, t, c, rdy;
    logic [2:0] idx, row, col;
    cmd_t e;
    beat_t b;
    c_out = 0;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk_t); n++; end
    if (!req_ready) begin check("req_ready_timeout", 32'(req_ready), 32'd1); return; end
    idx = addr[8:6]; row = addr[5:3]; col = addr[2:0];
    t = cyc + 1;
    if (!(ovld[idx] && orow[idx] == row)) begin
      if (ovld[idx]) begin
        e.cyc = t; e.kind = K_PRE; e.vec = 32'({3'b001, 1'b0, idx});
        cmd_q.push_back(e);
        t += T_RP;
      end
      e.cyc = t; e.kind = K_ACT; e.vec = 32'({3'b101, idx, row});
      cmd_q.push_back(e);
      t += T_RCD;
      ovld[idx] = 1'b1; orow[idx] = row;
    end
    c = t;
    e.cyc = c; e.kind = K_RW;
    e.vec = 32'({3'b010, ~we, idx, col, len, (len != 3'd0), ap});
    cmd_q.push_back(e);
    for (int k = 0; k <= int'(len); k++) begin
      if (we) begin
        wr_q.push_back(c + k);
        b.cyc = c + 1 + k; b.d = wd_tab[(c + k) % TAB];
        din_q.push_back(b);
      end else begin
        b.cyc = c + T_CL + 1 + k; b.d = do_tab[(c + T_CL + k) % TAB];
        rd_q.push_back(b);
      end
    end
    rdy = we ? (c + int'(len) + 2) : (c + T_CL + int'(len) + 2);
    if (ap) begin rdy += T_RP; ovld[idx] = 1'b0; end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_len = len; req_ap = ap;
    @(negedge clk_t);
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = 9'($urandom);
    req_len = 3'($urandom); req_ap = 1'($urandom);
    check("ready_low_after_accept", 32'(req_ready), 32'd0);
    c_out = c;
    if (wait_done) begin
      n = 0;
      while (!req_ready && n < 100) begin @(negedge clk_t); n++; end
      check("ready_return_cycle", cyc, rdy);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_cmd_pins", 32'({cs, act, ras, cas, rwb, auto_pre, burst_mode}), 32'b1011100);
    check("rst_addr", 32'({bank_grp, bank_no, row_address, col_address, burst_len}), 32'd0);
    check("rst_data", 32'({datain, rd_data}), 32'd0);
    check("rst_strobes", 32'({rd_valid, wd_ready, req_ready}), 32'd0);
  endtask

  initial begin
    int c, tgt;
    for (int i = 0; i < TAB; i++) begin
      wd_tab[i] = 16'($urandom);
      do_tab[i] = 16'($urandom);
    end
    for (int i = 0; i < 8; i++) begin ovld[i] = 1'b0; orow[i] = '0; end

    repeat (2) @(negedge clk_t);
    check_reset_outputs();
    #2 reset = 1'b1;
    @(negedge clk_t);
    check("ready_after_release", 32'(req_ready), 32'd1);

    do_req(1'b1, mk(0, 0, 5, 2), 3'd3, 1'b0, 1'b1, c);  // closed -> ACT
    do_req(1'b0, mk(0, 0, 5, 2), 3'd3, 1'b0, 1'b1, c);  // hit
    do_req(1'b0, mk(0, 0, 6, 0), 3'd0, 1'b0, 1'b1, c);  // miss -> PRE
    do_req(1'b1, mk(0, 0, 6, 1), 3'd0, 1'b1, 1'b1, c);  // hit, auto-precharge
    do_req(1'b0, mk(0, 0, 6, 1), 3'd0, 1'b0, 1'b1, c);  // entry cleared -> ACT
    do_req(1'b1, mk(1, 3, 2, 4), 3'd1, 1'b0, 1'b1, c);
    do_req(1'b0, mk(0, 0, 5, 0), 3'd2, 1'b0, 1'b1, c);
    do_req(1'b0, mk(1, 3, 2, 7), 3'd0, 1'b0, 1'b1, c);  // revisit -> hit
    do_req(1'b1, mk(0, 0, 5, 0), 3'd7, 1'b0, 1'b1, c);  // longest burst

    // Reset while read beat 2 is on rd_data.
    do_req(1'b0, mk(0, 0, 5, 3), 3'd3, 1'b0, 1'b0, c);
    tgt = c + T_CL + 1 + 2;
    while (cyc < tgt) @(negedge clk_t);
    #2 reset = 1'b0;
    #1 check_reset_outputs();
    cmd_q.delete(); wr_q.delete(); din_q.delete(); rd_q.delete();
    for (int i = 0; i < 8; i++) ovld[i] = 1'b0;
    repeat (2) @(negedge clk_t);
    check("no_rd_valid_in_reset", 32'(rd_valid), 32'd0);
    #2 reset = 1'b1;
    @(negedge clk_t);
    check("ready_after_rerelease", 32'(req_ready), 32'd1);
    do_req(1'b0, mk(0, 0, 5, 3), 3'd1, 1'b0, 1'b1, c);  // row lost -> ACT

    for (int r = 0; r < 150; r++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk_t);
      do_req(1'($urandom), mk($urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 7)),
             3'($urandom), ($urandom_range(0, 3) == 0), 1'b1, c);
    end

    repeat (4) @(negedge clk_t);
    check("cmd_q_drained", cmd_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
    check("din_q_drained", din_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
